// File: rtl/qed_pkg.sv
// Shared definitions for the QED consistency checker.
// Holds the FSM state encoding, the register-pair geometry and the field
// widths used by the checker and its sub-modules.
package qed_pkg;

  // Register pairs 1..15 are compared; pair 0/16 is never touched.
  localparam int unsigned NUM_PAIRS  = 15;
  // A duplicate instruction writes register (original index + DUP_OFFSET).
  localparam int unsigned DUP_OFFSET = 16;
  // Register-file address width.
  localparam int unsigned RF_AW      = 5;
  // Width of the pair index and of mismatch_idx.
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [2:0] {
    ST_COUNT     = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_RSP  = 3'd2,
    ST_DONE_OK   = 3'd3,
    ST_DONE_FAIL = 3'd4
  } qed_state_e;

endpackage

// File: rtl/qed_sat_counter.sv
// Saturating commit counter.
// Ports:
//   clk, resetn  - clock and asynchronous active-low reset
//   inc          - increment request
//   clr          - synchronous clear, wins over inc
//   count        - registered count value
//   count_nxt_c  - value count will take at the next rising edge
//   overflow_c   - increment attempted while already saturated (this cycle)
module qed_sat_counter #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic [COUNT_W-1:0] count_nxt_c,
  output logic               overflow_c
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               sat_c;

  // Next-value logic: clear, saturating increment or hold.
  always_comb begin
    count_d    = count_q;
    overflow_c = 1'b0;
    sat_c      = &count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (sat_c) begin
        overflow_c = 1'b1;
      end else begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/qed_consistency_checker.sv
// QED consistency checker.
// Counts retired original and duplicate instructions; once both counts match,
// are nonzero, the pipeline is empty and no counter overflowed, it reads the
// register pairs i / i+16 for i = 1..15 and compares the two data words.
// Ports:
//   clk, resetn                 - clock and asynchronous active-low reset
//   commit_valid, commit_is_dup - retire strobe and original/duplicate tag
//   pipeline_empty              - no instruction in flight
//   check_clear                 - restart counting, clears all status
//   rf_req, rf_raddr_a/b        - register-file read request and indices
//   rf_rvalid, rf_rdata_a/b     - register-file read response
//   num_orig, num_dup           - saturating commit counts
//   qed_ready                   - counts consistent, check may start
//   check_done, qed_mismatch    - check finished / finished with a mismatch
//   cnt_overflow                - sticky counter saturation flag
//   mismatch_idx                - pair index of the first mismatch
module qed_consistency_checker
  import qed_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               commit_valid,
  input  logic               commit_is_dup,
  input  logic               pipeline_empty,
  input  logic               check_clear,
  output logic               rf_req,
  output logic [RF_AW-1:0]   rf_raddr_a,
  output logic [RF_AW-1:0]   rf_raddr_b,
  input  logic               rf_rvalid,
  input  logic [XLEN-1:0]    rf_rdata_a,
  input  logic [XLEN-1:0]    rf_rdata_b,
  output logic [COUNT_W-1:0] num_orig,
  output logic [COUNT_W-1:0] num_dup,
  output logic               qed_ready,
  output logic               check_done,
  output logic               qed_mismatch,
  output logic               cnt_overflow,
  output logic [IDX_W-1:0]   mismatch_idx
);

  qed_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   mismatch_idx_q, mismatch_idx_d;
  logic               rf_req_q, rf_req_d;
  logic [RF_AW-1:0]   rf_raddr_a_q, rf_raddr_a_d;
  logic [RF_AW-1:0]   rf_raddr_b_q, rf_raddr_b_d;
  logic               qed_ready_q, qed_ready_d;
  logic               check_done_q, check_done_d;
  logic               qed_mismatch_q, qed_mismatch_d;
  logic               cnt_overflow_q, cnt_overflow_d;

  logic               inc_orig_c, inc_dup_c;
  logic               ovf_orig_c, ovf_dup_c;
  logic [COUNT_W-1:0] orig_nxt_c, dup_nxt_c;

  // A commit is always counted, except when check_clear drops it.
  assign inc_orig_c = commit_valid & ~commit_is_dup;
  assign inc_dup_c  = commit_valid &  commit_is_dup;

  qed_sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_cnt_orig (
    .clk         (clk),
    .resetn      (resetn),
    .inc         (inc_orig_c),
    .clr         (check_clear),
    .count       (num_orig),
    .count_nxt_c (orig_nxt_c),
    .overflow_c  (ovf_orig_c)
  );

  qed_sat_counter #(
    .COUNT_W (COUNT_W)
  ) u_cnt_dup (
    .clk         (clk),
    .resetn      (resetn),
    .inc         (inc_dup_c),
    .clr         (check_clear),
    .count       (num_dup),
    .count_nxt_c (dup_nxt_c),
    .overflow_c  (ovf_dup_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    mismatch_idx_d = mismatch_idx_q;

    if (check_clear) begin
      state_d        = ST_COUNT;
      idx_d          = IDX_W'(1);
      mismatch_idx_d = '0;
    end else begin
      unique case (state_q)
        ST_COUNT: begin
          if (qed_ready_q) begin
            state_d = ST_REQ;
            idx_d   = IDX_W'(1);
          end
        end
        ST_REQ: begin
          if (commit_valid) begin
            state_d = ST_COUNT;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          // A new commit invalidates the snapshot, so it beats a response.
          if (commit_valid) begin
            state_d = ST_COUNT;
            idx_d   = IDX_W'(1);
          end else if (rf_rvalid) begin
            if (rf_rdata_a != rf_rdata_b) begin
              state_d        = ST_DONE_FAIL;
              mismatch_idx_d = idx_q;
            end else if (idx_q == IDX_W'(NUM_PAIRS)) begin
              state_d = ST_DONE_OK;
            end else begin
              state_d = ST_REQ;
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE_OK:   state_d = ST_DONE_OK;
        ST_DONE_FAIL: state_d = ST_DONE_FAIL;
        default: begin
          state_d = ST_COUNT;
          idx_d   = IDX_W'(1);
        end
      endcase
    end

    // Outputs follow the state being entered so they line up with state_q.
    rf_req_d       = (state_d == ST_REQ) || (state_d == ST_WAIT_RSP);
    rf_raddr_a_d   = '0;
    rf_raddr_b_d   = '0;
    if (rf_req_d) begin
      rf_raddr_a_d = RF_AW'(idx_d);
      rf_raddr_b_d = RF_AW'(idx_d) + RF_AW'(DUP_OFFSET);
    end
    check_done_d   = (state_d == ST_DONE_OK) || (state_d == ST_DONE_FAIL);
    qed_mismatch_d = (state_d == ST_DONE_FAIL);

    cnt_overflow_d = !check_clear && (cnt_overflow_q || ovf_orig_c || ovf_dup_c);

    // Evaluated on the counter values of the next cycle so qed_ready never
    // lags a commit and cannot restart a check that was just aborted.
    qed_ready_d    = !check_clear && (orig_nxt_c == dup_nxt_c) &&
                     (orig_nxt_c != '0) && pipeline_empty && !cnt_overflow_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_COUNT;
      idx_q          <= IDX_W'(1);
      mismatch_idx_q <= '0;
      rf_req_q       <= 1'b0;
      rf_raddr_a_q   <= '0;
      rf_raddr_b_q   <= '0;
      qed_ready_q    <= 1'b0;
      check_done_q   <= 1'b0;
      qed_mismatch_q <= 1'b0;
      cnt_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      mismatch_idx_q <= mismatch_idx_d;
      rf_req_q       <= rf_req_d;
      rf_raddr_a_q   <= rf_raddr_a_d;
      rf_raddr_b_q   <= rf_raddr_b_d;
      qed_ready_q    <= qed_ready_d;
      check_done_q   <= check_done_d;
      qed_mismatch_q <= qed_mismatch_d;
      cnt_overflow_q <= cnt_overflow_d;
    end
  end

  assign rf_req       = rf_req_q;
  assign rf_raddr_a   = rf_raddr_a_q;
  assign rf_raddr_b   = rf_raddr_b_q;
  assign qed_ready    = qed_ready_q;
  assign check_done   = check_done_q;
  assign qed_mismatch = qed_mismatch_q;
  assign cnt_overflow = cnt_overflow_q;
  assign mismatch_idx = mismatch_idx_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Directed bench for qed_consistency_checker: a default instance and a
// COUNT_W=4 instance for the saturation scenario.
module tb_qed_consistency_checker;

  logic        clk;
  logic        resetn;
  logic        commit_valid, commit_is_dup, pipeline_empty, check_clear;
  logic        rf_req;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic        rf_rvalid;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic [15:0] num_orig, num_dup;
  logic        qed_ready, check_done, qed_mismatch, cnt_overflow;
  logic [3:0]  mismatch_idx;

  logic        c4_valid, c4_dup, pe4, clr4;
  logic        rf_req4;
  logic [4:0]  raddr_a4, raddr_b4;
  logic [3:0]  num_orig4, num_dup4;
  logic        ready4, done4, mism4, ovf4;
  logic [3:0]  midx4;

  int n_checks = 0;
  int n_pass   = 0;

  qed_consistency_checker #(.XLEN(32), .COUNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .commit_valid(commit_valid), .commit_is_dup(commit_is_dup),
    .pipeline_empty(pipeline_empty), .check_clear(check_clear),
    .rf_req(rf_req), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rvalid(rf_rvalid), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .num_orig(num_orig), .num_dup(num_dup),
    .qed_ready(qed_ready), .check_done(check_done), .qed_mismatch(qed_mismatch),
    .cnt_overflow(cnt_overflow), .mismatch_idx(mismatch_idx)
  );

  qed_consistency_checker #(.XLEN(32), .COUNT_W(4)) dut4 (
    .clk(clk), .resetn(resetn),
    .commit_valid(c4_valid), .commit_is_dup(c4_dup),
    .pipeline_empty(pe4), .check_clear(clr4),
    .rf_req(rf_req4), .rf_raddr_a(raddr_a4), .rf_raddr_b(raddr_b4),
    .rf_rvalid(1'b0), .rf_rdata_a(32'd0), .rf_rdata_b(32'd0),
    .num_orig(num_orig4), .num_dup(num_dup4),
    .qed_ready(ready4), .check_done(done4), .qed_mismatch(mism4),
    .cnt_overflow(ovf4), .mismatch_idx(midx4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic dup);
    commit_valid  = 1'b1;
    commit_is_dup = dup;
    step();
    commit_valid  = 1'b0;
    commit_is_dup = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!rf_req && n < 20) begin
      step();
      n++;
    end
    chk("rf_req_seen", 32'(rf_req), 32'd1);
  endtask

  // Serve one pair read: check the request, hold one cycle in WAIT_RSP, respond.
  task automatic serve_pair(input int i, input logic [31:0] a, input logic [31:0] b);
    wait_req();
    chk($sformatf("raddr_a_p%0d", i), 32'(rf_raddr_a), 32'(i));
    chk($sformatf("raddr_b_p%0d", i), 32'(rf_raddr_b), 32'(i + 16));
    step();
    chk($sformatf("hold_req_p%0d", i), 32'(rf_req), 32'd1);
    chk($sformatf("hold_addr_p%0d", i), 32'(rf_raddr_a), 32'(i));
    rf_rvalid  = 1'b1;
    rf_rdata_a = a;
    rf_rdata_b = b;
    step();
    rf_rvalid  = 1'b0;
    rf_rdata_a = '0;
    rf_rdata_b = '0;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_num_orig"}, 32'(num_orig), 32'd0);
    chk({pfx, "_num_dup"}, 32'(num_dup), 32'd0);
    chk({pfx, "_rf_req"}, 32'(rf_req), 32'd0);
    chk({pfx, "_raddr_a"}, 32'(rf_raddr_a), 32'd0);
    chk({pfx, "_raddr_b"}, 32'(rf_raddr_b), 32'd0);
    chk({pfx, "_ready"}, 32'(qed_ready), 32'd0);
    chk({pfx, "_done"}, 32'(check_done), 32'd0);
    chk({pfx, "_mismatch"}, 32'(qed_mismatch), 32'd0);
    chk({pfx, "_ovf"}, 32'(cnt_overflow), 32'd0);
    chk({pfx, "_midx"}, 32'(mismatch_idx), 32'd0);
  endtask

  initial begin
    int seen;
    resetn = 1'b0;
    commit_valid = 0; commit_is_dup = 0; pipeline_empty = 1; check_clear = 0;
    rf_rvalid = 0; rf_rdata_a = '0; rf_rdata_b = '0;
    c4_valid = 0; c4_dup = 0; pe4 = 1; clr4 = 0;
    repeat (3) step();
    check_reset_vals("rst");
    resetn = 1'b1;
    step();

    // Scenario A: 3 originals, 3 duplicates, all 15 pairs equal.
    commit(1'b0); commit(1'b0); commit(1'b0);
    commit(1'b1); commit(1'b1);
    chk("A_ready_early", 32'(qed_ready), 32'd0);
    commit(1'b1);
    chk("A_num_orig", 32'(num_orig), 32'd3);
    chk("A_num_dup", 32'(num_dup), 32'd3);
    chk("A_ready", 32'(qed_ready), 32'd1);
    for (int i = 1; i <= 15; i++) serve_pair(i, 32'hA5A5_0000 | 32'(i), 32'hA5A5_0000 | 32'(i));
    chk("A_done", 32'(check_done), 32'd1);
    chk("A_mismatch", 32'(qed_mismatch), 32'd0);
    chk("A_rf_req_off", 32'(rf_req), 32'd0);
    step();
    chk("A_done_sticky", 32'(check_done), 32'd1);

    // Scenario B: pair 7 differs (0x5 vs 0x6), no read for pair 8.
    check_clear = 1'b1; step(); check_clear = 1'b0;
    chk("B_clr_orig", 32'(num_orig), 32'd0);
    chk("B_clr_done", 32'(check_done), 32'd0);
    commit(1'b0); commit(1'b1); commit(1'b0); commit(1'b1);
    chk("B_ready", 32'(qed_ready), 32'd1);
    for (int i = 1; i <= 6; i++) serve_pair(i, 32'(i * 3), 32'(i * 3));
    serve_pair(7, 32'h5, 32'h6);
    chk("B_mismatch", 32'(qed_mismatch), 32'd1);
    chk("B_done", 32'(check_done), 32'd1);
    chk("B_midx", 32'(mismatch_idx), 32'd7);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rf_req) seen++;
      step();
    end
    chk("B_no_pair8_req", 32'(seen), 32'd0);

    // Scenario C: commits keep counting in DONE_FAIL, then clear beats a commit.
    commit(1'b0);
    chk("C_count_in_fail", 32'(num_orig), 32'd3);
    chk("C_still_fail", 32'(qed_mismatch), 32'd1);
    check_clear = 1'b1; commit_valid = 1'b1; commit_is_dup = 1'b0;
    step();
    check_clear = 1'b0; commit_valid = 1'b0;
    chk("C_num_orig", 32'(num_orig), 32'd0);
    chk("C_num_dup", 32'(num_dup), 32'd0);
    chk("C_mismatch", 32'(qed_mismatch), 32'd0);
    chk("C_done", 32'(check_done), 32'd0);
    chk("C_midx", 32'(mismatch_idx), 32'd0);
    chk("C_ready", 32'(qed_ready), 32'd0);

    // Scenario D: commit during WAIT_RSP of pair 4 aborts the check.
    commit(1'b0); commit(1'b1);
    for (int i = 1; i <= 3; i++) serve_pair(i, 32'hFFFF_0000, 32'hFFFF_0000);
    wait_req();
    chk("D_addr_p4", 32'(rf_raddr_a), 32'd4);
    step();
    chk("D_in_wait", 32'(rf_req), 32'd1);
    commit(1'b0);
    chk("D_req_dropped", 32'(rf_req), 32'd0);
    chk("D_num_orig", 32'(num_orig), 32'd2);
    chk("D_num_dup", 32'(num_dup), 32'd1);
    chk("D_ready", 32'(qed_ready), 32'd0);
    step(); step();
    chk("D_stay_idle", 32'(rf_req), 32'd0);
    chk("D_no_done", 32'(check_done), 32'd0);

    // Scenario E: reset mid-WAIT_RSP, late response ignored.
    check_clear = 1'b1; step(); check_clear = 1'b0;
    commit(1'b1); commit(1'b0);
    wait_req();
    step();
    chk("E_in_wait", 32'(rf_req), 32'd1);
    resetn = 1'b0;
    #2;
    chk("E_async_req", 32'(rf_req), 32'd0);
    resetn = 1'b1;
    rf_rvalid = 1'b1; rf_rdata_a = 32'h1; rf_rdata_b = 32'h2;
    step();
    rf_rvalid = 1'b0; rf_rdata_a = '0; rf_rdata_b = '0;
    check_reset_vals("E");
    step();
    chk("E_no_req", 32'(rf_req), 32'd0);

    // Scenario F: COUNT_W=4 saturation blocks qed_ready.
    for (int k = 0; k < 15; k++) begin
      c4_valid = 1'b1; c4_dup = 1'b0; step();
    end
    chk("F_orig_15", 32'(num_orig4), 32'd15);
    chk("F_ovf_early", 32'(ovf4), 32'd0);
    step();
    c4_valid = 1'b0;
    chk("F_orig_sat", 32'(num_orig4), 32'd15);
    chk("F_ovf", 32'(ovf4), 32'd1);
    for (int k = 0; k < 15; k++) begin
      c4_valid = 1'b1; c4_dup = 1'b1; step();
    end
    c4_valid = 1'b0; c4_dup = 1'b0;
    chk("F_dup_15", 32'(num_dup4), 32'd15);
    chk("F_ready", 32'(ready4), 32'd0);
    step(); step();
    chk("F_ready_later", 32'(ready4), 32'd0);
    chk("F_no_req", 32'(rf_req4), 32'd0);
    chk("F_ovf_sticky", 32'(ovf4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qed_consistency_checker.md
QED_CONSISTENCY_CHECKER -- requirements
Module: qed_consistency_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter COUNT_W, default 16, width of the commit counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port commit_valid, input, 1, one instruction retired this cycle.
REQ-006 SHALL have port commit_is_dup, input, 1, retired instruction is a duplicate (1) or an original (0); qualified by commit_valid.
REQ-007 SHALL have port pipeline_empty, input, 1, no instruction in flight.
REQ-008 SHALL have port check_clear, input, 1, single-cycle request to restart counting.
REQ-009 SHALL have port rf_req, output, 1, register-file read request.
REQ-010 SHALL have ports rf_raddr_a and rf_raddr_b, output, 5 each, original and duplicate register indices.
REQ-011 SHALL have port rf_rvalid, input, 1, read data valid pulse.
REQ-012 SHALL have ports rf_rdata_a and rf_rdata_b, input, XLEN each, read data.
REQ-013 SHALL have ports num_orig and num_dup, output, COUNT_W each, saturating commit counts.
REQ-014 SHALL have outputs qed_ready, check_done, qed_mismatch and cnt_overflow, 1 each, plus mismatch_idx, output, 4 bits.

Function
REQ-015 SHALL increment num_orig when commit_valid is high and commit_is_dup is low, and increment num_dup when both are high; result is visible the next cycle.
REQ-016 SHALL saturate each counter at all-ones and set the sticky cnt_overflow flag when an increment is attempted at saturation.
REQ-017 SHALL drive qed_ready registered high iff num_orig==num_dup, num_orig!=0, pipeline_empty is high, and cnt_overflow is low.
REQ-018 SHALL implement FSM states COUNT, REQ, WAIT_RSP, DONE_OK and DONE_FAIL; state is COUNT after reset.
REQ-019 SHALL transition COUNT->REQ in the cycle qed_ready is high, with pair index i=1.
REQ-020 SHALL, in REQ, drive rf_req=1, rf_raddr_a=i and rf_raddr_b=i+16, then go to WAIT_RSP the next cycle.
REQ-021 SHALL, in WAIT_RSP, hold rf_req and both addresses stable until rf_rvalid is high; rf_rvalid is ignored when rf_req is low.
REQ-022 SHALL, on rf_rvalid, compare the data words: on inequality go to DONE_FAIL and latch mismatch_idx=i; on equality with i==15 go to DONE_OK; otherwise increment i and return to REQ.
REQ-023 SHALL abort the check when commit_valid is high in REQ or WAIT_RSP, return to COUNT, deassert rf_req the next cycle, and still count that commit.
REQ-024 SHALL hold check_done=1 in DONE_OK and DONE_FAIL, and hold qed_mismatch=1 in DONE_FAIL only; both states are sticky and commits keep counting.
REQ-025 SHALL, on check_clear in any state, clear the counters, cnt_overflow, mismatch_idx and flags, and enter COUNT the next cycle; check_clear takes priority over a simultaneous commit, which is dropped.
REQ-026 SHALL never compare register pair 0/16.

Reset
REQ-027 SHALL on resetn low asynchronously force state COUNT, i=1, num_orig=0, num_dup=0, rf_req=0, rf_raddr_a=0, rf_raddr_b=0, qed_ready=0, check_done=0, qed_mismatch=0, cnt_overflow=0 and mismatch_idx=0.
REQ-028 SHALL, on reset during REQ or WAIT_RSP, drop rf_req immediately and discard any in-flight response.

Structure
REQ-029 SHALL take the FSM state enum, the pair count (15) and the duplicate register offset (16) from the shared package qed_pkg.
REQ-030 SHALL instantiate the sub-module qed_sat_counter (COUNT_W, increment, clear, overflow) twice, once for originals and once for duplicates.

Verification
REQ-031 SHALL cover: 3 originals then 3 duplicates with pipeline_empty=1 -> qed_ready=1 one cycle after the 6th commit, then 15 reads with equal data -> check_done=1 and qed_mismatch=0.
REQ-032 SHALL cover: equal counts with pair 7 returning 0x5 vs 0x6 -> qed_mismatch=1, mismatch_idx=7, and no read issued for pair 8.
REQ-033 SHALL cover: a commit during WAIT_RSP of pair 4 -> return to COUNT, rf_req=0 the next cycle, num_orig or num_dup incremented.
REQ-034 SHALL cover: COUNT_W=4 with 16 originals -> num_orig=15, cnt_overflow=1, and qed_ready stays 0 after 15 duplicates.
REQ-035 SHALL cover: resetn pulsed low mid-WAIT_RSP, then a late rf_rvalid -> all outputs at reset values and the response ignored.
REQ-036 SHALL cover: check_clear coincident with a commit in DONE_FAIL -> counters 0 and flags 0 the next cycle.
